// File: rtl/bru_pkg.sv
// Shared types and constants for the branch resolve unit: FSM state, the per-stage
// prediction record, and the instruction size used for fall-through PCs.
package bru_pkg;

    localparam int BRU_PC_W    = 32;
    localparam int INSTR_BYTES = 4;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } bru_state_t;

    // PC_W of the top must not exceed BRU_PC_W; narrower PCs are zero-extended here.
    typedef struct packed {
        logic                valid;
        logic [BRU_PC_W-1:0] pc;
        logic                pred_taken;
        logic [BRU_PC_W-1:0] pred_target;
    } bru_stage_t;

endpackage

// File: rtl/bru_stage_reg.sv
// One pipeline register carrying a prediction record. hold freezes the contents,
// kill clears only the valid bit and takes priority over hold.
module bru_stage_reg
    import bru_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       hold,
    input  logic       kill,
    input  bru_stage_t d,
    output bru_stage_t q
);

    bru_stage_t stage_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage_reg <= '0;
        end else begin
            if (!hold) begin
                stage_reg <= d;
            end
            if (kill) begin
                stage_reg.valid <= 1'b0;
            end
        end
    end

    assign q = stage_reg;

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: compares carried predictions with actual outcomes,
// trains the predictor and redirects fetch. Optional counters via BRU_STATS_EN.
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int PC_W  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_f,
    input  logic [PC_W-1:0]  pc_f,
    input  logic             pred_taken_f,
    input  logic [PC_W-1:0]  pred_target_f,
    input  logic             stall_d,
    input  logic             is_branch_e,
    input  logic             is_jal_e,
    input  logic             is_jalr_e,
    input  logic             cond_taken_e,
    input  logic [PC_W-1:0]  act_target_e,
    output logic             redirect_valid,
    input  logic             redirect_ready,
    output logic [PC_W-1:0]  redirect_pc,
    output logic             flush_d,
    output logic             flush_e,
    output logic             state_update_en,
    output logic             actual_taken_e,
    output logic [PC_W-1:0]  pc_e,
    output logic [CNT_W-1:0] resolved_cnt,
    output logic [CNT_W-1:0] mispredict_cnt
);

    bru_stage_t f_stage;
    bru_stage_t d_stage;
    bru_stage_t e_stage;

    bru_state_t      state_reg;
    bru_state_t      state_next;
    logic [PC_W-1:0] hold_pc_reg;
    logic [PC_W-1:0] hold_pc_next;

    logic            res;
    logic            mispredict;
    logic [PC_W-1:0] e_pred_target;
    logic [PC_W-1:0] fix_pc;

    assign f_stage = '{valid:       valid_f,
                       pc:          BRU_PC_W'(pc_f),
                       pred_taken:  pred_taken_f,
                       pred_target: BRU_PC_W'(pred_target_f)};

    bru_stage_reg u_stage_d (
        .clk   (clk),
        .reset (reset),
        .hold  (stall_d),
        .kill  (flush_d),
        .d     (f_stage),
        .q     (d_stage)
    );

    // A stall turns the EX slot into a bubble, so each instruction resolves once.
    bru_stage_reg u_stage_e (
        .clk   (clk),
        .reset (reset),
        .hold  (1'b0),
        .kill  (flush_e | stall_d),
        .d     (d_stage),
        .q     (e_stage)
    );

    assign pc_e          = e_stage.pc[PC_W-1:0];
    assign e_pred_target = e_stage.pred_target[PC_W-1:0];

    assign actual_taken_e  = is_jal_e | is_jalr_e | (is_branch_e & cond_taken_e);
    assign res             = e_stage.valid & (is_branch_e | is_jal_e | is_jalr_e)
                             & (state_reg == RUN);
    assign mispredict      = res & ((actual_taken_e != e_stage.pred_taken)
                             | (actual_taken_e & (e_pred_target != act_target_e)));
    assign fix_pc          = actual_taken_e ? act_target_e : pc_e + PC_W'(INSTR_BYTES);
    assign state_update_en = res & is_branch_e;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= RUN;
            hold_pc_reg <= '0;
        end else begin
            state_reg   <= state_next;
            hold_pc_reg <= hold_pc_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        hold_pc_next   = hold_pc_reg;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        flush_d        = 1'b0;
        flush_e        = 1'b0;
        unique case (state_reg)
            RUN: begin
                if (mispredict) begin
                    redirect_valid = 1'b1;
                    redirect_pc    = fix_pc;
                    flush_d        = 1'b1;
                    flush_e        = 1'b1;
                    if (!redirect_ready) begin
                        state_next   = HOLD;
                        hold_pc_next = fix_pc;
                    end
                end
            end
            HOLD: begin
                // Keep squashing the wrong path until fetch takes the redirect.
                redirect_valid = 1'b1;
                redirect_pc    = hold_pc_reg;
                flush_d        = 1'b1;
                flush_e        = 1'b1;
                if (redirect_ready) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

`ifdef BRU_STATS_EN
    logic [CNT_W-1:0] resolved_reg;
    logic [CNT_W-1:0] mispredict_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resolved_reg   <= '0;
            mispredict_reg <= '0;
        end else begin
            if (res && (resolved_reg != '1)) begin
                resolved_reg <= resolved_reg + CNT_W'(1);
            end
            if (mispredict && (mispredict_reg != '1)) begin
                mispredict_reg <= mispredict_reg + CNT_W'(1);
            end
        end
    end

    assign resolved_cnt   = resolved_reg;
    assign mispredict_cnt = mispredict_reg;
`else
    assign resolved_cnt   = '0;
    assign mispredict_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed instructions push expected
// EX-stage responses; a negedge monitor pops them whenever redirect or training fires.
module tb_branch_resolve_unit;

`ifdef BRU_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_f, pred_taken_f, stall_d;
    logic [31:0] pc_f, pred_target_f, act_target_e;
    logic        is_branch_e, is_jal_e, is_jalr_e, cond_taken_e;
    logic        redirect_valid, redirect_ready;
    logic [31:0] redirect_pc, pc_e, resolved_cnt, mispredict_cnt;
    logic        flush_d, flush_e, state_update_en, actual_taken_e;

    always #5 clk = ~clk;

    branch_resolve_unit #(.PC_W(32), .CNT_W(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .valid_f         (valid_f),
        .pc_f            (pc_f),
        .pred_taken_f    (pred_taken_f),
        .pred_target_f   (pred_target_f),
        .stall_d         (stall_d),
        .is_branch_e     (is_branch_e),
        .is_jal_e        (is_jal_e),
        .is_jalr_e       (is_jalr_e),
        .cond_taken_e    (cond_taken_e),
        .act_target_e    (act_target_e),
        .redirect_valid  (redirect_valid),
        .redirect_ready  (redirect_ready),
        .redirect_pc     (redirect_pc),
        .flush_d         (flush_d),
        .flush_e         (flush_e),
        .state_update_en (state_update_en),
        .actual_taken_e  (actual_taken_e),
        .pc_e            (pc_e),
        .resolved_cnt    (resolved_cnt),
        .mispredict_cnt  (mispredict_cnt)
    );

    typedef struct {
        string       name;
        logic        su;
        logic        at;
        logic        rv;
        logic [31:0] rpc;
        logic        fd;
        logic        fe;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   flush_cycles = 0;

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (flush_d) flush_cycles++;
            if (redirect_valid || state_update_en) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_event: got rv=%0b su=%0b rpc=%h, required no event",
                             redirect_valid, state_update_en, redirect_pc);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({state_update_en, actual_taken_e, redirect_valid, flush_d, flush_e}
                            !== {mon_e.su, mon_e.at, mon_e.rv, mon_e.fd, mon_e.fe}
                        || redirect_pc !== mon_e.rpc) begin
                        fails++;
                        $display("FAIL %s: got su=%0b at=%0b rv=%0b rpc=%h fd=%0b fe=%0b, required su=%0b at=%0b rv=%0b rpc=%h fd=%0b fe=%0b",
                                 mon_e.name, state_update_en, actual_taken_e, redirect_valid,
                                 redirect_pc, flush_d, flush_e, mon_e.su, mon_e.at, mon_e.rv,
                                 mon_e.rpc, mon_e.fd, mon_e.fe);
                    end else begin
                        $display("[TB] %s: su=%0b at=%0b rv=%0b rpc=%h", mon_e.name,
                                 state_update_en, actual_taken_e, redirect_valid, redirect_pc);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end else begin
            $display("[TB] %s: %h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_f(input logic v, input logic [31:0] pc, input logic pt, input logic [31:0] tg);
        valid_f       = v;
        pc_f          = pc;
        pred_taken_f  = pt;
        pred_target_f = tg;
    endtask

    task automatic drive_e(input logic br, input logic jal, input logic jalr, input logic cond,
                           input logic [31:0] tg);
        is_branch_e  = br;
        is_jal_e     = jal;
        is_jalr_e    = jalr;
        cond_taken_e = cond;
        act_target_e = tg;
    endtask

    task automatic push(input string name, input logic su, input logic at, input logic rv,
                        input logic [31:0] rpc, input logic fd, input logic fe);
        exp_t x;
        x.name = name; x.su = su; x.at = at; x.rv = rv; x.rpc = rpc; x.fd = fd; x.fe = fe;
        exp_q.push_back(x);
    endtask

    // F -> D -> E in two edges; EX inputs are applied for the cycle the instruction sits in E.
    task automatic issue(input string name, input logic [31:0] pc, input logic pt,
                         input logic [31:0] ptg, input logic br, input logic jal,
                         input logic jalr, input logic cond, input logic [31:0] atg,
                         input logic rdy, input logic ev, input logic su, input logic at,
                         input logic rv, input logic [31:0] rpc);
        drive_f(1'b1, pc, pt, ptg);
        tick();
        drive_f(1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        drive_e(br, jal, jalr, cond, atg);
        redirect_ready = rdy;
        if (ev) push(name, su, at, rv, rpc, rv, rv);
        tick();
        drive_e(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        int fc0;
        reset = 1'b0;
        stall_d = 1'b0;
        redirect_ready = 1'b1;
        drive_f(1'b0, 32'h0, 1'b0, 32'h0);
        drive_e(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        tick();
        check("reset_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        check("reset_redirect_pc", redirect_pc, 32'd0);
        check("reset_flush", {30'd0, flush_d, flush_e}, 32'd0);
        check("reset_pc_e", pc_e, 32'd0);
        check("reset_resolved_cnt", resolved_cnt, 32'd0);
        reset = 1'b1;
        tick();
        tick();

        issue("beq_correct", 32'h100, 1'b1, 32'h140, 1, 0, 0, 1, 32'h140, 1'b1,
              1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        issue("bne_mispredict", 32'h200, 1'b1, 32'h240, 1, 0, 0, 0, 32'h240, 1'b1,
              1'b1, 1'b1, 1'b0, 1'b1, 32'h204);
        issue("jalr_target_miss", 32'h300, 1'b1, 32'h400, 0, 0, 1, 0, 32'h480, 1'b1,
              1'b1, 1'b0, 1'b1, 1'b1, 32'h480);
        tick();

        fc0 = flush_cycles;
        issue("hold_entry", 32'h500, 1'b0, 32'h0, 1, 0, 0, 1, 32'h520, 1'b0,
              1'b1, 1'b1, 1'b1, 1'b1, 32'h520);
        push("hold_cycle1", 1'b0, 1'b0, 1'b1, 32'h520, 1'b1, 1'b1);
        tick();
        push("hold_cycle2", 1'b0, 1'b0, 1'b1, 32'h520, 1'b1, 1'b1);
        tick();
        redirect_ready = 1'b1;
        push("hold_cycle3_accept", 1'b0, 1'b0, 1'b1, 32'h520, 1'b1, 1'b1);
        tick();
        check("hold_flush_cycles", flush_cycles - fc0, 32'd4);
        tick();

        // Wrap-around fall-through while stall_d is high: one resolution only.
        drive_f(1'b1, 32'hFFFF_FFFC, 1'b1, 32'h8);
        tick();
        drive_f(1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        drive_e(1'b1, 1'b0, 1'b0, 1'b0, 32'h8);
        stall_d = 1'b1;
        push("wrap_mispredict", 1'b1, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b1);
        tick();
        tick();
        stall_d = 1'b0;
        drive_e(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();

        // Branch held in D by a 2-cycle stall enters EX once and trains once.
        drive_f(1'b1, 32'h600, 1'b0, 32'h0);
        tick();
        drive_f(1'b0, 32'h0, 1'b0, 32'h0);
        stall_d = 1'b1;
        drive_e(1'b1, 1'b0, 1'b0, 1'b0, 32'h640);
        tick();
        tick();
        stall_d = 1'b0;
        tick();
        check("stall_pc_e", pc_e, 32'h600);
        push("stall_branch_once", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        drive_e(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();

        issue("jal_correct", 32'h700, 1'b1, 32'h800, 0, 1, 0, 0, 32'h800, 1'b1,
              1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("cnt_resolved_7", resolved_cnt, STATS ? 32'd7 : 32'd0);
        check("cnt_mispredict_4", mispredict_cnt, STATS ? 32'd4 : 32'd0);

        // Ten predicted-taken branches; i = 2, 5, 8 fall through instead.
        for (int i = 0; i < 10; i++) begin
            logic [31:0] pc;
            logic        mis;
            pc  = 32'h1000 + 32'(i) * 32'h10;
            mis = (i % 3 == 2);
            issue($sformatf("loop_br%0d", i), pc, 1'b1, pc + 32'h20, 1, 0, 0, !mis,
                  pc + 32'h20, 1'b1, 1'b1, 1'b1, !mis, mis, mis ? pc + 32'h4 : 32'h0);
        end
        check("cnt_resolved_17", resolved_cnt, STATS ? 32'd17 : 32'd0);
        check("cnt_mispredict_7", mispredict_cnt, STATS ? 32'd7 : 32'd0);

        // Asynchronous reset pulse while holding a redirect.
        issue("rst_hold_entry", 32'h900, 1'b0, 32'h0, 1, 0, 0, 1, 32'h940, 1'b0,
              1'b1, 1'b1, 1'b1, 1'b1, 32'h940);
        check("cnt_resolved_18", resolved_cnt, STATS ? 32'd18 : 32'd0);
        check("cnt_mispredict_8", mispredict_cnt, STATS ? 32'd8 : 32'd0);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        check("async_rst_flush", {30'd0, flush_d, flush_e}, 32'd0);
        check("async_rst_redirect_pc", redirect_pc, 32'd0);
        check("async_rst_resolved_cnt", resolved_cnt, 32'd0);
        check("async_rst_mispredict_cnt", mispredict_cnt, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick();
        tick();
        check("post_rst_idle", {31'd0, redirect_valid}, 32'd0);
        redirect_ready = 1'b1;
        tick();

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
